// File: rtl/ahb3lite_pkg.sv
// Shared AHB-lite / APB bridge definitions.
// Holds the bus width, APB completer state type and its default ID word.
package ahb3lite_pkg;

    localparam int PDATA_SIZE = 32;

    localparam logic [PDATA_SIZE-1:0] APB_SLV_ID_DEFAULT = 32'hA9B0_0001;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } apb_slv_state_t;

    // Expand byte strobes into a bit mask over the data word.
    function automatic logic [PDATA_SIZE-1:0] apb_strb_mask(
        input logic [PDATA_SIZE/8-1:0] strb
    );
        logic [PDATA_SIZE-1:0] m;
        m = '0;
        for (int b = 0; b < PDATA_SIZE/8; b++) begin
            m[8*b +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB4 bus bundle between the bridge (requester) and a completer.
// Clock and reset are carried as plain ports by the modules.
interface apb_slave_regfile_if;
    import ahb3lite_pkg::*;

    logic                    PSEL;
    logic                    PENABLE;
    logic [2:0]              PPROT;
    logic                    PWRITE;
    logic [PDATA_SIZE/8-1:0] PSTRB;
    logic [PDATA_SIZE-1:0]   PADDR;
    logic [PDATA_SIZE-1:0]   PWDATA;
    logic [PDATA_SIZE-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport master (
        output PSEL, PENABLE, PPROT, PWRITE, PSTRB, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PPROT, PWRITE, PSTRB, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_regfile_storage.sv
// Word register array with byte-strobe writes, read mux and ID word.
// Index 0 always reads the ID constant; commits pulse wr_pulse_o.
module apb_regfile_storage
    import ahb3lite_pkg::*;
#(
    parameter int                    NUM_REGS = 16,
    parameter logic [PDATA_SIZE-1:0] ID_VALUE = APB_SLV_ID_DEFAULT
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           we_i,
    input  logic [$clog2(NUM_REGS)-1:0]    idx_i,
    input  logic [PDATA_SIZE-1:0]          wdata_i,
    input  logic [PDATA_SIZE/8-1:0]        strb_i,
    output logic [PDATA_SIZE-1:0]          rd_data_o,
    output logic [NUM_REGS*PDATA_SIZE-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    logic [PDATA_SIZE-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   pulse_q;
    logic [NUM_REGS-1:0]   pulse_d;
    logic [PDATA_SIZE-1:0] mask;

    assign mask = apb_strb_mask(strb_i);

    // One-hot pulse for the register being committed this edge.
    always_comb begin
        pulse_d = '0;
        if (we_i) begin
            pulse_d[idx_i] = 1'b1;
        end
    end

    // Byte-lane merge into the addressed register on commit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            pulse_q <= '0;
        end else begin
            pulse_q <= pulse_d;
            if (we_i) begin
                regs_q[idx_i] <= (regs_q[idx_i] & ~mask) | (wdata_i & mask);
            end
        end
    end

    assign rd_data_o  = (idx_i == '0) ? ID_VALUE : regs_q[idx_i];
    assign wr_pulse_o = pulse_q;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        if (i == 0) begin : g_id
            assign regs_o[i*PDATA_SIZE +: PDATA_SIZE] = ID_VALUE;
        end else begin : g_reg
            assign regs_o[i*PDATA_SIZE +: PDATA_SIZE] = regs_q[i];
        end
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB4 completer: setup capture, fixed wait states, registered response.
// Writes commit on the completion edge; errors never touch state.
module apb_slave_regfile
    import ahb3lite_pkg::*;
#(
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_CYCLES = 1,
    parameter logic [PDATA_SIZE-1:0] ID_VALUE    = APB_SLV_ID_DEFAULT
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    apb_slave_regfile_if.slave             bus,
    output logic [NUM_REGS*PDATA_SIZE-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    localparam int IW = $clog2(NUM_REGS);
    localparam int SW = PDATA_SIZE/8;
    localparam logic [PDATA_SIZE-1:0] ADDR_LIM = PDATA_SIZE'(NUM_REGS*4);

    apb_slv_state_t        state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [PDATA_SIZE-1:0] addr_q, wdata_q;
    logic [SW-1:0]         strb_q;
    logic                  write_q;
    logic                  ready_q, ready_d;
    logic                  slverr_q, slverr_d;
    logic [PDATA_SIZE-1:0] rdata_q, rdata_d;
    logic                  cap, we, err, cur_write, access;
    logic [PDATA_SIZE-1:0] cur_addr, rd_data, resp_data;
    logic [IW-1:0]         idx;
    logic                  unused_prot;

    assign unused_prot = ^bus.PPROT;

    // In IDLE the live bus is decoded so a zero-wait access can respond at once.
    assign cur_addr  = (state_q == IDLE) ? bus.PADDR  : addr_q;
    assign cur_write = (state_q == IDLE) ? bus.PWRITE : write_q;
    assign idx       = cur_addr[IW+1:2];
    assign err       = (cur_addr[1:0] != 2'b00) || (cur_addr >= ADDR_LIM)
                     || (cur_write && (idx == '0));
    assign resp_data = (err || cur_write) ? '0 : rd_data;
    assign access    = bus.PSEL && bus.PENABLE;

    // Next-state, response and commit decisions.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = 1'b0;
        slverr_d = 1'b0;
        rdata_d  = '0;
        cap      = 1'b0;
        we       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.PSEL && !bus.PENABLE) begin
                    cap   = 1'b1;
                    cnt_d = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d  = RESP;
                        ready_d  = 1'b1;
                        slverr_d = err;
                        rdata_d  = resp_data;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!access) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd1) begin
                    state_d  = RESP;
                    cnt_d    = '0;
                    ready_d  = 1'b1;
                    slverr_d = err;
                    rdata_d  = resp_data;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                we      = access && write_q && !err;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and registered bus outputs.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            slverr_q <= slverr_d;
            rdata_q  <= rdata_d;
        end
    end

    // Transfer attributes captured in the setup phase.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            write_q <= 1'b0;
        end else if (cap) begin
            addr_q  <= bus.PADDR;
            wdata_q <= bus.PWDATA;
            strb_q  <= bus.PSTRB;
            write_q <= bus.PWRITE;
        end
    end

    assign bus.PREADY  = ready_q;
    assign bus.PSLVERR = slverr_q;
    assign bus.PRDATA  = rdata_q;

    apb_regfile_storage #(
        .NUM_REGS (NUM_REGS),
        .ID_VALUE (ID_VALUE)
    ) u_store (
        .clk_i      (PCLK),
        .rst_ni     (PRESETn),
        .we_i       (we),
        .idx_i      (idx),
        .wdata_i    (wdata_q),
        .strb_i     (strb_q),
        .rd_data_o  (rd_data),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o)
    );

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances (1, 0 and 3 wait states)
// share one requester; a timing/register model is checked every cycle.
module tb_apb_slave_regfile;

    localparam logic [31:0] ID = 32'hA9B0_0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        b_psel = 1'b0, b_pen = 1'b0, b_write = 1'b0;
    logic [31:0] b_addr = '0, b_wdata = '0;
    logic [3:0]  b_strb = '0;
    int          sel = 0;
    int          cyc = 0;

    logic [511:0] regs_w  [3];
    logic [15:0]  pulse_w [3];
    logic         rdy_w   [3];
    logic         err_w   [3];
    logic [31:0]  rdata_w [3];

    int wc [3] = '{1, 0, 3};

    logic [31:0] mregs [3][16];
    int          exp_k = -1, exp_ready_at = -1;
    logic [31:0] exp_rdata = '0;
    logic        exp_err = 1'b0;
    int          commit_k = -1, commit_cyc = -1, commit_idx = 0;
    logic [31:0] commit_wd = '0;
    logic [3:0]  commit_st = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int WC = (k == 0) ? 1 : (k == 1) ? 0 : 3;
        apb_slave_regfile_if bus();
        assign bus.PSEL    = b_psel && (sel == k);
        assign bus.PENABLE = b_pen;
        assign bus.PPROT   = 3'b000;
        assign bus.PWRITE  = b_write;
        assign bus.PSTRB   = b_strb;
        assign bus.PADDR   = b_addr;
        assign bus.PWDATA  = b_wdata;
        assign rdy_w[k]    = bus.PREADY;
        assign err_w[k]    = bus.PSLVERR;
        assign rdata_w[k]  = bus.PRDATA;
        apb_slave_regfile #(
            .NUM_REGS    (16),
            .WAIT_CYCLES (WC),
            .ID_VALUE    (ID)
        ) u_dut (
            .PCLK       (clk),
            .PRESETn    (rst_n),
            .bus        (bus),
            .regs_o     (regs_w[k]),
            .wr_pulse_o (pulse_w[k])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++) mregs[k][i] = '0;
        exp_ready_at = -1;
        commit_cyc   = -1;
    endtask

    function automatic logic model_err(input logic wr, input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= 16) || (wr && (a / 4 == 0));
    endfunction

    function automatic logic [31:0] model_rd(input int k, input logic [31:0] a);
        return (a / 4 == 0) ? ID : mregs[k][a / 4];
    endfunction

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (cyc == commit_cyc) begin
            for (int b = 0; b < 4; b++)
                if (commit_st[b])
                    mregs[commit_k][commit_idx][8*b +: 8] = commit_wd[8*b +: 8];
        end
        for (int k = 0; k < 3; k++) begin
            logic        er;
            logic [15:0] ep;
            er = (k == exp_k) && (cyc == exp_ready_at);
            ep = '0;
            if (k == commit_k && cyc == commit_cyc) ep[commit_idx] = 1'b1;
            chk($sformatf("pready%0d", k), 32'(rdy_w[k]), 32'(er));
            chk($sformatf("prdata%0d", k), rdata_w[k], er ? exp_rdata : 32'h0);
            chk($sformatf("pslverr%0d", k), 32'(err_w[k]), er ? 32'(exp_err) : 32'h0);
            chk($sformatf("pulse%0d", k), 32'(pulse_w[k]), 32'(ep));
            for (int i = 0; i < 16; i++)
                chk($sformatf("reg%0d_%0d", k, i), regs_w[k][32*i +: 32],
                    (i == 0) ? ID : mregs[k][i]);
        end
    end

    task automatic xfer(input int k, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st, input logic ab,
                        output logic [31:0] rd, output logic er, output int lat);
        int  n0;
        logic got, e;
        rd = '0; er = 1'b0; lat = -1; got = 1'b0;
        sel = k; b_psel = 1'b1; b_pen = 1'b0; b_write = wr;
        b_addr = a; b_wdata = wd; b_strb = st;
        @(posedge clk); #1;
        n0 = cyc;
        if (!ab) begin
            e            = model_err(wr, a);
            exp_k        = k;
            exp_ready_at = n0 + wc[k];
            exp_err      = e;
            exp_rdata    = (!wr && !e) ? model_rd(k, a) : 32'h0;
            if (wr && !e) begin
                commit_k   = k;
                commit_idx = int'(a / 4);
                commit_wd  = wd;
                commit_st  = st;
                commit_cyc = n0 + wc[k] + 1;
            end
        end
        b_pen = 1'b1;
        if (ab) begin
            @(posedge clk); #1;
            b_psel = 1'b0; b_pen = 1'b0;
            repeat (6) @(posedge clk);
            #1;
        end else begin
            for (int n = 0; n < 40 && !got; n++) begin
                @(negedge clk);
                if (rdy_w[k]) begin
                    got = 1'b1; rd = rdata_w[k]; er = err_w[k]; lat = cyc - n0;
                end
            end
            if (!got) chk("ready_timeout", 32'h0, 32'h1);
            @(posedge clk); #1;
            b_psel = 1'b0; b_pen = 1'b0;
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_pready", 32'(rdy_w[0]), 32'h0);
        chk("rst_prdata", rdata_w[0], 32'h0);
        chk("rst_id", regs_w[0][31:0], ID);

        // Reset in the middle of a wait state: nothing commits.
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        sel = 0; b_psel = 1'b1; b_pen = 1'b0; b_write = 1'b1;
        b_addr = 32'h4; b_wdata = 32'hDEADBEEF; b_strb = 4'hF;
        @(posedge clk); #1;
        b_pen = 1'b1;
        #2;
        rst_n = 1'b0; b_psel = 1'b0; b_pen = 1'b0;
        model_reset();
        @(negedge clk);
        chk("midrst_pready", 32'(rdy_w[0]), 32'h0);
        chk("midrst_prdata", rdata_w[0], 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_reg1", regs_w[0][63:32], 32'h0);

        xfer(0, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 1'b0, rd, er, lat);
        chk("wr4_lat", 32'(lat), 32'd1);
        chk("wr4_err", 32'(er), 32'h0);
        xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0, rd, er, lat);
        chk("rd4_data", rd, 32'hDEADBEEF);

        xfer(0, 1'b1, 32'h8, 32'h11223344, 4'hF, 1'b0, rd, er, lat);
        xfer(0, 1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, 1'b0, rd, er, lat);
        xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, rd, er, lat);
        chk("rd8_strb", rd, 32'h11BB33DD);

        xfer(0, 1'b0, 32'h3, 32'h0, 4'h0, 1'b0, rd, er, lat);
        chk("rd3_err", 32'(er), 32'h1);
        chk("rd3_data", rd, 32'h0);
        xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, rd, er, lat);
        chk("rd40_err", 32'(er), 32'h1);
        chk("rd40_data", rd, 32'h0);
        xfer(0, 1'b1, 32'h0, 32'hFFFFFFFF, 4'hF, 1'b0, rd, er, lat);
        chk("wr0_err", 32'(er), 32'h1);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, rd, er, lat);
        chk("rd0_id", rd, ID);
        chk("rd0_err", 32'(er), 32'h0);
        chk("err_reg2", regs_w[0][95:64], 32'h11BB33DD);

        xfer(1, 1'b1, 32'hC, 32'h12345678, 4'hF, 1'b0, rd, er, lat);
        chk("w0_wr_lat", 32'(lat), 32'd0);
        xfer(1, 1'b0, 32'hC, 32'h0, 4'h0, 1'b0, rd, er, lat);
        chk("w0_rd_lat", 32'(lat), 32'd0);
        chk("w0_rd_data", rd, 32'h12345678);

        xfer(2, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 1'b1, rd, er, lat);
        chk("abort_reg4", regs_w[2][159:128], 32'h0);
        xfer(2, 1'b1, 32'h10, 32'h0BADC0DE, 4'hF, 1'b0, rd, er, lat);
        chk("w3_wr_lat", 32'(lat), 32'd3);
        xfer(2, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, er, lat);
        chk("w3_rd_data", rd, 32'h0BADC0DE);

        repeat (4) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
